// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command/response stream plus the APB segment driven by the bridge.
// master modport is the bridge's view; slave modport is the view of whatever sits around it.
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int SEL_BITS   = 3,
  parameter int NUM_SLAVES = 5
);
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic                             cmd_write;
  logic [ADDR_WIDTH-1:0]            cmd_addr;
  logic [31:0]                      cmd_wdata;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [31:0]                      rsp_rdata;
  logic                             rsp_err;
  logic [ADDR_WIDTH-SEL_BITS-1:0]   apb_PADDR;
  logic [NUM_SLAVES-1:0]            apb_PSEL;
  logic                             apb_PENABLE;
  logic                             apb_PWRITE;
  logic [31:0]                      apb_PWDATA;
  logic [NUM_SLAVES-1:0]            apb_PREADY;
  logic [32*NUM_SLAVES-1:0]         apb_PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, apb_PREADY, apb_PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           apb_PADDR, apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, apb_PREADY, apb_PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           apb_PADDR, apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB initiator with one-hot slave decode.
// Optional ACCESS timeout is enabled by defining APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a command (cmd_ready high)
// SETUP  | APB setup phase, PSEL high, PENABLE low
// ACCESS | APB access phase, waiting for the selected PREADY
// RESP   | response held on rsp_* until rsp_ready
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int SEL_BITS   = 3,
  parameter int NUM_SLAVES = 5,
  parameter int TIMEOUT    = 4096
) (
  input logic                  clk,
  input logic                  reset,
  apb_master_bridge_if.master  bus
);
  localparam int OW = ADDR_WIDTH - SEL_BITS;
  localparam int IW = SEL_BITS + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_write;
  logic [OW-1:0]         r_addr;
  logic [31:0]           r_wdata;
  logic [SEL_BITS-1:0]   r_idx;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic [SEL_BITS-1:0]   w_cmd_idx;
  logic                  w_idx_ok;
  logic [NUM_SLAVES-1:0] w_sel;
  logic                  w_pready;
  logic [31:0]           w_prdata;
  logic                  w_done;
  logic                  w_abort;

  if (NUM_SLAVES > (1 << SEL_BITS) || TIMEOUT < 2) begin : g_bad_cfg
    $error("apb_master_bridge: NUM_SLAVES exceeds 2**SEL_BITS or TIMEOUT below 2");
  end

  assign w_cmd_idx = bus.cmd_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_idx_ok  = {1'b0, w_cmd_idx} < IW'(NUM_SLAVES);

  // Select the latched slave: one-hot PSEL pattern plus its PREADY/PRDATA; others are ignored.
  always_comb begin
    w_sel    = '0;
    w_pready = 1'b0;
    w_prdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_idx == SEL_BITS'(i)) begin
        w_sel[i] = 1'b1;
        w_pready = bus.apb_PREADY[i];
        w_prdata = bus.apb_PRDATA[32*i +: 32];
      end
    end
  end

  assign w_done = (r_state == ACCESS) && w_pready;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] r_tmo;

  // Count ACCESS cycles; held at zero outside ACCESS so each transfer starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_tmo <= '0;
    else if (r_state != ACCESS) r_tmo <= '0;
    else                        r_tmo <= r_tmo + 1'b1;
  end

  // A PREADY in the expiry cycle takes priority over the abort.
  assign w_abort = (r_state == ACCESS) && !w_pready && (r_tmo == TW'(TIMEOUT - 1));
`else
  assign w_abort = 1'b0;
`endif

  // State register; reset returns to IDLE immediately so PSEL/PENABLE drop asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.cmd_valid) w_next = w_idx_ok ? SETUP : RESP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (w_done || w_abort) w_next = RESP;
      RESP:    if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Command latch and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_idx   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.cmd_valid) begin
        r_write <= bus.cmd_write;
        r_addr  <= bus.cmd_addr[OW-1:0];
        r_wdata <= bus.cmd_wdata;
        r_idx   <= w_cmd_idx;
        if (!w_idx_ok) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
      if (w_done) begin
        r_rdata <= r_write ? 32'h0 : w_prdata;
        r_err   <= 1'b0;
      end else if (w_abort) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready   = (r_state == IDLE);
  assign bus.rsp_valid   = (r_state == RESP);
  assign bus.rsp_rdata   = r_rdata;
  assign bus.rsp_err     = r_err;
  assign bus.apb_PSEL    = (r_state == SETUP || r_state == ACCESS) ? w_sel : '0;
  assign bus.apb_PENABLE = (r_state == ACCESS);
  assign bus.apb_PADDR   = r_addr;
  assign bus.apb_PWRITE  = r_write;
  assign bus.apb_PWDATA  = r_wdata;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed plus random transfers against a per-transaction reference model.
module tb_apb_master_bridge;
  localparam int AW  = 16;
  localparam int SB  = 3;
  localparam int NS  = 5;
  localparam int TMO = 16;

  logic clk;
  logic reset;
  logic [NS-1:0]    pready_v;
  logic [32*NS-1:0] prdata_v;
  int n_checks = 0;
  int n_pass   = 0;

  apb_master_bridge_if #(.ADDR_WIDTH(AW), .SEL_BITS(SB), .NUM_SLAVES(NS)) bus ();

  apb_master_bridge #(.ADDR_WIDTH(AW), .SEL_BITS(SB), .NUM_SLAVES(NS), .TIMEOUT(TMO)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.apb_PREADY = pready_v;
  assign bus.apb_PRDATA = prdata_v;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Random noise on every slave, then the selected one gets its fixed data and ready value.
  task automatic drive_slaves(input int idx, input logic [31:0] d, input bit rdy);
    for (int i = 0; i < NS; i++) begin
      pready_v[i]           = 1'($urandom_range(0, 1));
      prdata_v[32*i +: 32]  = $urandom;
    end
    if (idx < NS) begin
      pready_v[idx]          = rdy;
      prdata_v[32*idx +: 32] = d;
    end
  endtask

  task automatic run_txn(input logic [15:0] addr, input bit wr, input logic [31:0] wd,
                         input logic [31:0] rd_val, input int waits, input int hold, input bit pend);
    int idx;
    int budget;
    int acc_cycles;
    bit timed_out;
    bit exp_err;
    logic [31:0] exp_rd;
    logic [NS-1:0] exp_sel;
    logic [12:0] exp_paddr;

    idx       = int'(addr >> 13);
    exp_paddr = addr[12:0];
    exp_sel   = '0;
    if (idx < NS) exp_sel[idx] = 1'b1;
`ifdef APB_TIMEOUT_EN
    timed_out = (idx < NS) && (waits >= TMO);
`else
    timed_out = 1'b0;
`endif
    acc_cycles = timed_out ? TMO : waits + 1;
    exp_err    = (idx >= NS) || timed_out;
    exp_rd     = (exp_err || wr) ? 32'h0 : rd_val;

    budget = 0;
    while (!bus.cmd_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("cmd_ready_idle", bus.cmd_ready, 1);

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    drive_slaves(idx, rd_val, 1'b0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = 16'($urandom);
    bus.cmd_wdata = $urandom;

    if (idx < NS) begin
      chk("setup_psel", bus.apb_PSEL, exp_sel);
      chk("setup_penable", bus.apb_PENABLE, 0);
      chk("setup_paddr", bus.apb_PADDR, exp_paddr);
      chk("setup_pwrite", bus.apb_PWRITE, wr);
      chk("setup_pwdata", bus.apb_PWDATA, wd);
      chk("setup_rsp_valid", bus.rsp_valid, 0);
      drive_slaves(idx, rd_val, 1'($urandom_range(0, 1)));
      @(negedge clk);
      for (int k = 0; k < acc_cycles; k++) begin
        chk("access_psel", bus.apb_PSEL, exp_sel);
        chk("access_penable", bus.apb_PENABLE, 1);
        chk("access_paddr", bus.apb_PADDR, exp_paddr);
        chk("access_pwrite", bus.apb_PWRITE, wr);
        chk("access_pwdata", bus.apb_PWDATA, wd);
        chk("access_rsp_valid", bus.rsp_valid, 0);
        drive_slaves(idx, rd_val, k == waits);
        @(negedge clk);
      end
      drive_slaves(idx, rd_val, 1'b0);
    end

    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_psel", bus.apb_PSEL, 0);
    chk("rsp_penable", bus.apb_PENABLE, 0);
    chk("rsp_cmd_ready", bus.cmd_ready, 0);
    if (pend) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_err", bus.rsp_err, exp_err);
      chk("hold_rsp_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_cmd_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_cmd_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    int r;
    int waits;
    clk           = 1'b0;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    pready_v      = '0;
    prdata_v      = '0;
    #12;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_psel", bus.apb_PSEL, 0);
    chk("rst_penable", bus.apb_PENABLE, 0);
    chk("rst_pwrite", bus.apb_PWRITE, 0);
    chk("rst_paddr", bus.apb_PADDR, 0);
    chk("rst_pwdata", bus.apb_PWDATA, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_txn(16'h0008, 1'b0, 32'h0, 32'h0000019F, 0, 0, 1'b0);
    run_txn(16'h4004, 1'b1, 32'h41, 32'hDEAD_BEEF, 5, 1, 1'b0);
    run_txn(16'hA000, 1'b0, 32'h0, 32'h1234_5678, 0, 0, 1'b0);
    run_txn(16'h8000, 1'b0, 32'h0, 32'hCAFE_0004, 1, 0, 1'b0);
    run_txn(16'h2010, 1'b0, 32'h0, 32'h0BAD_F00D, 2, 10, 1'b1);
    run_txn(16'h2010, 1'b0, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b0);
    run_txn(16'h6000, 1'b0, 32'h0, 32'h7777_0003, 100, 0, 1'b0);
    run_txn(16'h6004, 1'b0, 32'h0, 32'h7777_0004, TMO - 1, 0, 1'b0);
    run_txn(16'hE000, 1'b1, 32'h55, 32'h0, 0, 2, 1'b0);

    for (int t = 0; t < 40; t++) begin
      r     = $urandom_range(0, 9);
      waits = (r < 7) ? $urandom_range(0, 3) : $urandom_range(TMO - 2, TMO + 1);
      run_txn(16'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom,
              waits, $urandom_range(0, 3), 1'b0);
    end

    // Reset in the middle of ACCESS.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 16'h2010;
    drive_slaves(1, 32'h1111_2222, 1'b0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    drive_slaves(1, 32'h1111_2222, 1'b0);
    @(negedge clk);
    chk("pre_rst_penable", bus.apb_PENABLE, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_psel", bus.apb_PSEL, 0);
    chk("midrst_penable", bus.apb_PENABLE, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("after_rst_cmd_ready", bus.cmd_ready, 1);
    chk("after_rst_rsp_valid", bus.rsp_valid, 0);
    chk("after_rst_psel", bus.apb_PSEL, 0);
    chk("after_rst_rdata", bus.rsp_rdata, 0);
    run_txn(16'h0100, 1'b0, 32'h0, 32'hA5A5_5A5A, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
